// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq -- sequential multiply/divide unit for the ALU M-extension ops.
//
// Purpose:
//   Accepts one request at a time (valid/ready), computes mul/div/rem in
//   64-bit (N-bit) or 32-bit "W" form, and presents the result on a
//   valid/ready output handshake. Divide uses restoring shift-subtract on
//   operand magnitudes; multiply uses shift-add. One bit per cycle.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE and not in reset)
//   sel[4:0]   op code: 2 mul, 3 div, 4 divu, 5 rem, 6 remu,
//              24 mulw, 25 divw, 26 divuw, 27 remw, 28 remuw
//   A[N-1:0]   dividend / multiplicand
//   B[N-1:0]   divisor / multiplier
//   flush      abort any in-flight op; no result is delivered
//   out_valid  result valid (state DONE)
//   out_ready  consumer accepts result
//   res[N-1:0] result, held stable while out_valid is high
//   busy       high whenever the block is not IDLE
//
// Configuration:
//   ALU_MDU_FAST_MUL_EN  when defined, mul/mulw are computed with a single
//                        combinational multiply at accept and complete one
//                        edge later; when undefined they iterate bit-serially.
//
// N is expected to be at least 32 so that the W forms are meaningful.

module alu_mdu_seq #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   sel,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  // acc: partial remainder (divide) or running product (multiply)
  // q:   dividend shifting into quotient (divide) or multiplier (multiply)
  // d:   divisor magnitude (divide) or shifting multiplicand (multiply)
  logic [N-1:0]   acc_reg, acc_next;
  logic [N-1:0]   q_reg, q_next;
  logic [N-1:0]   d_reg, d_next;
  logic [N-1:0]   res_reg, res_next;
  logic           mul_reg, mul_next;
  logic           rem_reg, rem_next;
  logic           w_reg, w_next;
  logic           negq_reg, negq_next;
  logic           negr_reg, negr_next;

  // 32-bit to N-bit sign / zero extension helpers
  function automatic logic [N-1:0] sx32(input logic [31:0] x);
    logic signed [N-1:0] t;
    t = $signed(x);
    return t;
  endfunction

  function automatic logic [N-1:0] zx32(input logic [31:0] x);
    logic [N-1:0] t;
    t = x;
    return t;
  endfunction

  // ---------------------------------------------------------------
  // Request decode (combinational on the input operands)
  // ---------------------------------------------------------------
  logic         op_mul, op_quo, op_rem, op_sgn, op_w, op_ok;
  logic [N-1:0] a_ext, b_ext, a_mag, b_mag, a_w;
  logic         a_neg, b_neg, b_zero, ovf, accept;
  logic [CW-1:0] iters;

  always_comb begin
    op_mul = 1'b0;
    op_quo = 1'b0;
    op_rem = 1'b0;
    op_sgn = 1'b0;
    op_w   = 1'b0;
    case (sel)
      5'd2:  op_mul = 1'b1;
      5'd3:  begin op_quo = 1'b1; op_sgn = 1'b1; end
      5'd4:  op_quo = 1'b1;
      5'd5:  begin op_rem = 1'b1; op_sgn = 1'b1; end
      5'd6:  op_rem = 1'b1;
      5'd24: begin op_mul = 1'b1; op_w = 1'b1; end
      5'd25: begin op_quo = 1'b1; op_sgn = 1'b1; op_w = 1'b1; end
      5'd26: begin op_quo = 1'b1; op_w = 1'b1; end
      5'd27: begin op_rem = 1'b1; op_sgn = 1'b1; op_w = 1'b1; end
      5'd28: begin op_rem = 1'b1; op_w = 1'b1; end
      default: ;
    endcase
    op_ok = op_mul | op_quo | op_rem;

    a_w   = sx32(A[31:0]);
    a_ext = op_w ? (op_sgn ? a_w : zx32(A[31:0])) : A;
    b_ext = op_w ? (op_sgn ? sx32(B[31:0]) : zx32(B[31:0])) : B;
    a_neg = op_sgn & a_ext[N-1];
    b_neg = op_sgn & b_ext[N-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    b_zero = op_w ? (B[31:0] == 32'd0) : (B == '0);
    // most-negative / -1 is the only signed quotient that does not fit
    ovf = op_sgn & (op_w ? ((A[31:0] == 32'h8000_0000) && (B[31:0] == 32'hFFFF_FFFF))
                         : ((A == {1'b1, {(N-1){1'b0}}}) && (&B)));
    iters = op_w ? CW'(32) : CW'(N);
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign res       = res_reg;

  // ---------------------------------------------------------------
  // One iteration of the bit-serial datapath
  // ---------------------------------------------------------------
  logic [N-1:0] acc_s, q_s, d_s, fin;
  logic [N:0]   sh;

  always_comb begin
    sh = {acc_reg, q_reg[N-1]};
    if (mul_reg) begin
      acc_s = q_reg[0] ? (acc_reg + d_reg) : acc_reg;
      q_s   = q_reg >> 1;
      d_s   = d_reg << 1;
    end else begin
      // restoring step: remainder stays below the divisor, so N bits suffice
      if (sh >= {1'b0, d_reg}) begin
        acc_s = N'(sh - {1'b0, d_reg});
        q_s   = {q_reg[N-2:0], 1'b1};
      end else begin
        acc_s = sh[N-1:0];
        q_s   = {q_reg[N-2:0], 1'b0};
      end
      d_s = d_reg;
    end

    if (mul_reg)
      fin = acc_s;
    else if (rem_reg)
      fin = negr_reg ? -acc_s : acc_s;
    else
      fin = negq_reg ? -q_s : q_s;
    if (w_reg)
      fin = sx32(fin[31:0]);
  end

  // ---------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    res_next   = res_reg;
    mul_next   = mul_reg;
    rem_next   = rem_reg;
    w_next     = w_reg;
    negq_next  = negq_reg;
    negr_next  = negr_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          mul_next  = op_mul;
          rem_next  = op_rem;
          w_next    = op_w;
          negq_next = a_neg ^ b_neg;
          negr_next = a_neg;
          if (!op_ok) begin
            res_next   = '0;
            state_next = DONE;
          end else if (!op_mul && b_zero) begin
            res_next   = op_quo ? '1 : (op_w ? a_w : A);
            state_next = DONE;
          end else if (!op_mul && ovf) begin
            res_next   = op_quo ? (op_w ? a_w : A) : '0;
            state_next = DONE;
          end else if (op_mul) begin
`ifdef ALU_MDU_FAST_MUL_EN
            // product is ready now; one pass through CALC with a zero
            // multiplier leaves it untouched and finalises it
            acc_next = op_w ? sx32(32'(A[31:0] * B[31:0])) : N'(A * B);
            q_next   = '0;
            d_next   = '0;
            cnt_next = CW'(1);
`else
            acc_next = '0;
            d_next   = a_ext;
            q_next   = b_ext;
            cnt_next = iters;
`endif
            state_next = CALC;
          end else begin
            acc_next = '0;
            d_next   = b_mag;
            // W dividends occupy the top 32 bits so 32 steps consume them all
            q_next   = op_w ? (a_mag << (N - 32)) : a_mag;
            cnt_next = iters;
            state_next = CALC;
          end
        end
      end
      CALC: begin
        acc_next = acc_s;
        q_next   = q_s;
        d_next   = d_s;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          res_next   = fin;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      res_reg   <= '0;
      mul_reg   <= 1'b0;
      rem_reg   <= 1'b0;
      w_reg     <= 1'b0;
      negq_reg  <= 1'b0;
      negr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      res_reg   <= res_next;
      mul_reg   <= mul_next;
      rem_reg   <= rem_next;
      w_reg     <= w_next;
      negq_reg  <= negq_next;
      negr_reg  <= negr_next;
    end
  end

endmodule

// File: doc/alu_mdu_seq.md
ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 SHALL have parameter N, default 64, meaning datapath width in bits.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 SHALL have in_valid  input  1  request valid.
REQ-005 SHALL have in_ready  output  1  block can accept a request.
REQ-006 SHALL have sel  input  5  op code in the ALU sel encoding: 2 mul, 3 div, 4 divu, 5 rem, 6 remu, 24 mulw, 25 divw, 26 divuw, 27 remw, 28 remuw.
REQ-007 SHALL have A  input  N  and  B  input  N  operands (dividend/multiplicand and divisor/multiplier).
REQ-008 SHALL have flush  input  1  abort any in-flight op.
REQ-009 SHALL have out_valid  output  1,  out_ready  input  1,  res  output  N  result handshake.
REQ-010 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 SHALL, in IDLE, drive in_ready=1 and accept on in_valid&&in_ready&&!flush, registering A, B and sel.
REQ-013 SHALL, on accept of an unsupported sel, go to DONE with res=0.
REQ-014 SHALL, on accept of a divide-class op with B==0 (low 32 bits for W ops), go to DONE with res = all-ones for div/divu, or A (W: A[31:0] sign-extended) for rem/remu.
REQ-015 SHALL, on accept of signed overflow (most-negative / -1, at width N or 32 for W), go to DONE with quotient = dividend and remainder = 0.
REQ-016 SHALL, otherwise, go to CALC and iterate one bit per cycle: N iterations for N-bit ops, 32 for W ops, using a down-counter.
REQ-017 SHALL divide by restoring shift-subtract on magnitudes; quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-018 SHALL multiply by shift-add; res = low N bits of the product (low 32 bits for mulw).
REQ-019 SHALL sign-extend bit 31 into res[N-1:32] for all W ops.
REQ-020 SHALL enter DONE on the edge that completes the final iteration: out_valid rises C+1 edges after the accept edge (C = iteration count), or 1 edge for REQ-013/014/015 cases.
REQ-021 SHALL, in DONE, hold out_valid=1 and res stable until out_ready=1; on that edge return to IDLE; in_ready=0 throughout CALC and DONE.
REQ-022 SHALL, on flush in any state, return to IDLE on the next edge, drop out_valid, and deliver no result; flush overrides a same-cycle accept and a same-cycle out_ready.

Reset
REQ-023 SHALL, while rst is high at an edge, set state=IDLE, out_valid=0, res=0, counter=0 and busy=0; in_ready SHALL be 0 while rst is high.
REQ-024 SHALL abandon any in-flight op on reset (same as flush), with no output handshake.

Configuration
REQ-025 SHALL honour macro ALU_MDU_FAST_MUL_EN: when defined, mul/mulw are computed combinationally at accept and reach DONE 1 edge later; when undefined, they iterate per REQ-016/018. Divide behaviour is unaffected.

Verification
REQ-026 SHALL check divu A=100 B=7 -> res=14 with out_valid 65 edges after accept; remu with the same operands -> res=2.
REQ-027 SHALL check div A=-7 B=2 -> res=-3; rem A=-7 B=2 -> res=-1; divw A=0xFFFF_FFF9 B=2 -> 0xFFFF_FFFF_FFFF_FFFD after 33 edges.
REQ-028 SHALL check divw A=5 B=0 -> 0xFFFF_FFFF_FFFF_FFFF; remw A=0x8000_0000 B=0 -> 0xFFFF_FFFF_8000_0000; both with 1-edge latency.
REQ-029 SHALL check div A=0x8000_0000_0000_0000 B=-1 -> res=A; rem with the same operands -> res=0.
REQ-030 SHALL check backpressure: out_ready held low 5 cycles in DONE -> res and out_valid stay stable and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-031 SHALL check flush asserted 10 cycles into a mul -> IDLE next edge, out_valid never rises, a new request is accepted the following cycle; also check mul A=3 B=5 -> 15 in 2 edges with the macro defined and 65 edges without.
